// File: rtl/apb_requester_pkg.sv
// ============================================================================
// Module   : apb_requester_pkg
// Purpose  : Shared types and constants for the APB4 requester.
// Revision : 1.0
// ============================================================================
`default_nettype none

package apb_requester_pkg;

    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_STRB_WIDTH = 4;
    localparam int APB_ADDR_MAX   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_MAX-1:0]   addr;
        logic [APB_DATA_WIDTH-1:0] wdata;
        logic [APB_STRB_WIDTH-1:0] strb;
    } cmd_t;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } rsp_t;

endpackage

`default_nettype wire

// File: rtl/apb_requester.sv
// ============================================================================
// Module   : apb_requester
// Purpose  : Single-outstanding APB4 requester bridging a valid/ready command
//            stream to APB transfers, with an optional wait-state timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_requester
    import apb_requester_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int TIMEOUT    = 0
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
    input  logic [APB_STRB_WIDTH-1:0] cmd_strb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [ADDR_WIDTH-1:0]     PADDR,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic [APB_STRB_WIDTH-1:0] PSTRB,
    input  logic                      PREADY,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PSLVERR
);

    // A zero TIMEOUT still gets a 1-bit counter; it simply never fires.
    localparam bit             TO_EN  = (TIMEOUT > 0);
    localparam int             CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     paddr_q, paddr_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [APB_STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    rsp_t                      rsp_q, rsp_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        rsp_d     = rsp_q;
        cnt_d     = cnt_q;
        psel_d    = 1'b0;
        penable_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // Completion has priority over the timeout in the limit cycle.
                if (PREADY) begin
                    rsp_d.rdata   = pwrite_q ? '0 : PRDATA;
                    rsp_d.err     = PSLVERR;
                    rsp_d.timeout = 1'b0;
                    state_d       = RESP;
                end else if (TO_EN && (cnt_q == CNT_MAX)) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    state_d       = RESP;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rsp_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rsp_q     <= rsp_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

    assign PADDR   = paddr_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;
    assign PSTRB   = pstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_requester.sv
// ============================================================================
// Module   : tb_apb_requester
// Purpose  : Self-checking bench for apb_requester with a behavioural
//            completer and a latency/response model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apb_requester;

    localparam int AW = 8;
    localparam int TO = 4;

    logic          PCLK;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [31:0]   PWDATA;
    logic [3:0]    PSTRB;
    logic          PREADY;
    logic [31:0]   PRDATA;
    logic          PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic       setup_ok;
        int         n_access;
        int         req_bad;
        int         rsp_bad;
        int         rsp_cyc;
        int         acc_cyc;
        int         hs_cyc;
        logic [31:0] rdata;
        logic       err;
        logic       to;
        logic [3:0] pstrb;
    } obs_t;

    apb_requester #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Model: cycles from accept to rsp_valid, and ACCESS cycles seen.
    function automatic int exp_latency(input int waits);
        return 3 + ((waits <= TO) ? waits : TO);
    endfunction

    function automatic int exp_naccess(input int waits);
        return 1 + ((waits <= TO) ? waits : TO);
    endfunction

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Drives one command and plays the completer; returns what was observed.
    task automatic run_xfer(input logic wr, input logic [AW-1:0] addr,
                            input logic [31:0] wd, input logic [3:0] st,
                            input int waits, input logic [31:0] rd,
                            input logic slv, input int bp, input logic pend,
                            output obs_t o);
        int   rel;
        int   idx;
        logic done;
        o.setup_ok = 1'b0; o.n_access = 0; o.req_bad = 0; o.rsp_bad = 0;
        o.rsp_cyc  = -1;   o.acc_cyc  = 0; o.hs_cyc  = 0;
        o.rdata    = '0;   o.err      = 1'b0; o.to = 1'b0; o.pstrb = '0;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
        cmd_valid = 1'b1; rsp_ready = 1'b0; PREADY = 1'b0;
        tick();
        o.acc_cyc  = cyc;
        cmd_valid  = 1'b0;
        o.setup_ok = (PSEL === 1'b1) && (PENABLE === 1'b0) && (cmd_ready === 1'b0);
        rel = 1; idx = 0; done = 1'b0;
        while (!done && rel < 40) begin
            if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                o.n_access++;
                if (PADDR !== addr || PWRITE !== wr || PWDATA !== wd ||
                    PSTRB !== (wr ? st : 4'h0) || cmd_ready !== 1'b0)
                    o.req_bad++;
                if (o.n_access == 1) o.pstrb = PSTRB;
                PREADY = (idx == waits); PRDATA = rd; PSLVERR = slv;
                idx++;
            end else begin
                PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
            end
            if (rsp_valid === 1'b1) begin
                o.rsp_cyc = rel; o.rdata = rsp_rdata; o.err = rsp_err; o.to = rsp_timeout;
                for (int k = 0; k < bp; k++) begin
                    rsp_ready = 1'b0;
                    cmd_valid = pend;
                    tick();
                    if (rsp_valid !== 1'b1 || rsp_rdata !== o.rdata || rsp_err !== o.err ||
                        rsp_timeout !== o.to || cmd_ready !== 1'b0 || PSEL !== 1'b0)
                        o.rsp_bad++;
                end
                rsp_ready = 1'b1;
                cmd_valid = pend;
                tick();
                o.hs_cyc  = cyc;
                rsp_ready = 1'b0;
                if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || PSEL !== 1'b0) o.rsp_bad++;
                done = 1'b1;
            end else begin
                tick();
                rel++;
            end
        end
        PREADY = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        tick(); tick();
        n_checks++;
        if ({cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 1000000",
                     {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout});
        end
        n_checks++;
        if (PADDR !== '0 || PWDATA !== '0 || PSTRB !== '0 || rsp_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr %h wdata %h strb %h rdata %h expected all 0",
                     PADDR, PWDATA, PSTRB, rsp_rdata);
        end
        PRESETn = 1'b1;
        tick();
    endtask

    task automatic test_write_basic();
        obs_t o;
        run_xfer(1'b1, 8'd1, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 0, 1'b0, o);
        n_checks++;
        if (o.setup_ok !== 1'b1) begin
            n_fail++; $display("FAIL wr_setup: got %b expected 1", o.setup_ok);
        end
        n_checks++;
        if (o.req_bad != 0 || o.n_access != 1) begin
            n_fail++; $display("FAIL wr_access: got bad %0d n %0d expected 0 1", o.req_bad, o.n_access);
        end
        n_checks++;
        if (o.rsp_cyc != exp_latency(0)) begin
            n_fail++; $display("FAIL wr_latency: got %0d expected %0d", o.rsp_cyc, exp_latency(0));
        end
        n_checks++;
        if (o.rdata !== 32'h0 || o.err !== 1'b0 || o.to !== 1'b0) begin
            n_fail++; $display("FAIL wr_rsp: got %h %b %b expected 0 0 0", o.rdata, o.err, o.to);
        end
        n_checks++;
        if (PADDR !== 8'd1 || PWDATA !== 32'hDEADBEEF || PWRITE !== 1'b1) begin
            n_fail++; $display("FAIL wr_hold: got %h %h %b expected 01 deadbeef 1", PADDR, PWDATA, PWRITE);
        end
    endtask

    task automatic test_read_wait();
        obs_t o;
        run_xfer(1'b0, 8'd0, 32'hA5A5A5A5, 4'hF, 2, 32'h12345678, 1'b0, 0, 1'b0, o);
        n_checks++;
        if (o.pstrb !== 4'h0 || o.req_bad != 0 || o.n_access != 3) begin
            n_fail++;
            $display("FAIL rd_req: got strb %h bad %0d n %0d expected 0 0 3", o.pstrb, o.req_bad, o.n_access);
        end
        n_checks++;
        if (o.rdata !== 32'h12345678 || o.err !== 1'b0 || o.rsp_cyc != exp_latency(2)) begin
            n_fail++;
            $display("FAIL rd_rsp: got %h err %b cyc %0d expected 12345678 0 %0d",
                     o.rdata, o.err, o.rsp_cyc, exp_latency(2));
        end
    endtask

    task automatic test_slverr();
        obs_t o;
        run_xfer(1'b1, 8'h3C, 32'h0BADF00D, 4'h3, 1, 32'hFFFFFFFF, 1'b1, 0, 1'b0, o);
        n_checks++;
        if (o.err !== 1'b1 || o.to !== 1'b0 || o.rdata !== 32'h0) begin
            n_fail++; $display("FAIL slverr: got err %b to %b rdata %h expected 1 0 0", o.err, o.to, o.rdata);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_xfer(1'b0, 8'h42, 32'h0, 4'h0, 100, 32'hCAFEF00D, 1'b0, 0, 1'b0, o);
        n_checks++;
        if (o.n_access != exp_naccess(100) || o.rsp_cyc != exp_latency(100)) begin
            n_fail++;
            $display("FAIL timeout_timing: got n %0d cyc %0d expected %0d %0d",
                     o.n_access, o.rsp_cyc, exp_naccess(100), exp_latency(100));
        end
        n_checks++;
        if (o.err !== 1'b1 || o.to !== 1'b1 || o.rdata !== 32'h0) begin
            n_fail++; $display("FAIL timeout_rsp: got err %b to %b rdata %h expected 1 1 0", o.err, o.to, o.rdata);
        end
        run_xfer(1'b0, 8'h43, 32'h0, 4'h0, TO, 32'h600DCAFE, 1'b0, 0, 1'b0, o);
        n_checks++;
        if (o.to !== 1'b0 || o.err !== 1'b0 || o.rdata !== 32'h600DCAFE || o.rsp_cyc != exp_latency(TO)) begin
            n_fail++;
            $display("FAIL timeout_limit: got to %b err %b rdata %h cyc %0d expected 0 0 600dcafe %0d",
                     o.to, o.err, o.rdata, o.rsp_cyc, exp_latency(TO));
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        obs_t o2;
        run_xfer(1'b0, 8'h10, 32'h0, 4'h0, 0, 32'h55AA55AA, 1'b0, 5, 1'b1, o);
        n_checks++;
        if (o.rsp_bad != 0 || o.rdata !== 32'h55AA55AA) begin
            n_fail++; $display("FAIL bp_hold: got bad %0d rdata %h expected 0 55aa55aa", o.rsp_bad, o.rdata);
        end
        run_xfer(1'b1, 8'h11, 32'h13572468, 4'hC, 0, 32'h0, 1'b0, 0, 1'b0, o2);
        n_checks++;
        if (o2.acc_cyc - o.hs_cyc != 1 || o2.req_bad != 0) begin
            n_fail++;
            $display("FAIL bp_accept: got gap %0d bad %0d expected 1 0", o2.acc_cyc - o.hs_cyc, o2.req_bad);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   seen;
        cmd_write = 1'b1; cmd_addr = 8'h77; cmd_wdata = 32'h89ABCDEF; cmd_strb = 4'hF;
        cmd_valid = 1'b1; PREADY = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        PRESETn = 1'b0; PREADY = 1'b1; PRDATA = 32'h11111111;
        tick();
        n_checks++;
        if ({cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 7'b1000000 ||
            PADDR !== '0 || PWDATA !== '0 || PSTRB !== '0 || rsp_rdata !== '0) begin
            n_fail++;
            $display("FAIL midreset_vals: got ctrl %b addr %h wdata %h strb %h expected 1000000 0 0 0",
                     {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}, PADDR, PWDATA, PSTRB);
        end
        PRESETn = 1'b1; PREADY = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rsp_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL midreset_norsp: got %0d rsp cycles expected 0", seen);
        end
        run_xfer(1'b0, 8'h05, 32'h0, 4'h0, 1, 32'hFEEDFACE, 1'b0, 0, 1'b0, o);
        n_checks++;
        if (o.rdata !== 32'hFEEDFACE || o.rsp_cyc != exp_latency(1) || o.req_bad != 0) begin
            n_fail++;
            $display("FAIL midreset_after: got %h cyc %0d bad %0d expected feedface %0d 0",
                     o.rdata, o.rsp_cyc, o.req_bad, exp_latency(1));
        end
    endtask

    task automatic test_random();
        obs_t        o;
        logic        wr;
        logic [AW-1:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  st;
        logic        slv;
        int          w;
        int          bp;
        logic        timed;
        for (int t = 0; t < 24; t++) begin
            wr  = 1'($urandom); a = AW'($urandom); wd = $urandom; rd = $urandom;
            st  = 4'($urandom); slv = 1'($urandom);
            w   = $urandom_range(0, 6); bp = $urandom_range(0, 3);
            run_xfer(wr, a, wd, st, w, rd, slv, bp, 1'b0, o);
            timed = (w > TO);
            n_checks++;
            if (o.setup_ok !== 1'b1 || o.req_bad != 0 || o.rsp_bad != 0 ||
                o.n_access != exp_naccess(w) || o.rsp_cyc != exp_latency(w)) begin
                n_fail++;
                $display("FAIL rand_proto[%0d]: got setup %b bad %0d/%0d n %0d cyc %0d expected 1 0/0 %0d %0d",
                         t, o.setup_ok, o.req_bad, o.rsp_bad, o.n_access, o.rsp_cyc,
                         exp_naccess(w), exp_latency(w));
            end
            n_checks++;
            if (o.rdata !== ((timed || wr) ? 32'h0 : rd) || o.err !== (timed ? 1'b1 : slv) ||
                o.to !== timed) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: got %h %b %b expected %h %b %b", t, o.rdata, o.err, o.to,
                         (timed || wr) ? 32'h0 : rd, timed ? 1'b1 : slv, timed);
            end
        end
    endtask

    initial begin
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        test_reset();
        test_write_basic();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
